// File: rtl/sram_banked_dp_if.sv
// Bus bundle for the banked dual-port SRAM: two access ports, init request, ready.
// master drives requests (bench / SoC side), slave is the memory.
interface sram_banked_dp_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 16
);
   logic                  en0;
   logic [DATA_W/8-1:0]   wea0;
   logic [ADDR_W-1:0]     addr0;
   logic [DATA_W-1:0]     wdata0;
   logic [DATA_W-1:0]     rdata0;
   logic                  rvalid0;
   logic                  err0;
   logic                  en1;
   logic [DATA_W/8-1:0]   wea1;
   logic [ADDR_W-1:0]     addr1;
   logic [DATA_W-1:0]     wdata1;
   logic [DATA_W-1:0]     rdata1;
   logic                  rvalid1;
   logic                  err1;
   logic                  init_req;
   logic                  ready;

   modport master (
      output en0, wea0, addr0, wdata0, en1, wea1, addr1, wdata1, init_req,
      input  rdata0, rvalid0, err0, rdata1, rvalid1, err1, ready
   );

   modport slave (
      input  en0, wea0, addr0, wdata0, en1, wea1, addr1, wdata1, init_req,
      output rdata0, rvalid0, err0, rdata1, rvalid1, err1, ready
   );
endinterface

// File: rtl/sram_banked_dp.sv
// Banked dual-port SRAM with byte enables, read-first collisions, port-0 write priority
// and a hardware zero-fill that sweeps one offset of every bank per cycle.
module sram_banked_dp #(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned DEPTH          = 16384,
   parameter int unsigned BANK_DEPTH     = 2048,
   parameter int unsigned ADDR_W         = 16,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input logic              clk,
   input logic              rst_n,
   sram_banked_dp_if.slave  bus
);
   localparam int unsigned NumBanks = DEPTH / BANK_DEPTH;
   localparam int unsigned NumBytes = DATA_W / 8;
   localparam int unsigned BankW    = (NumBanks > 1) ? $clog2(NumBanks) : 1;
   localparam int unsigned OffW     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;

   typedef enum logic [0:0] {StClear, StReady} state_e;

   state_e            state_q, state_d;
   logic [OffW-1:0]   cnt_q, cnt_d;
   logic              ready_q, ready_d;

   logic [DATA_W-1:0] mem [NumBanks][BANK_DEPTH];

   logic [1:0]          en;
   logic [NumBytes-1:0] wea   [2];
   logic [ADDR_W-1:0]   addr  [2];
   logic [DATA_W-1:0]   wdata [2];
   logic [BankW-1:0]    bank  [2];
   logic [OffW-1:0]     off   [2];
   logic [1:0]          in_rng, rd_req, wr_req;
   logic [1:0]          rvalid_d, rvalid_q, err_d, err_q;
   logic [DATA_W-1:0]   rdata_d [2];
   logic [DATA_W-1:0]   rdata_q [2];

   assign en       = {bus.en1, bus.en0};
   assign wea[0]   = bus.wea0;
   assign wea[1]   = bus.wea1;
   assign addr[0]  = bus.addr0;
   assign addr[1]  = bus.addr1;
   assign wdata[0] = bus.wdata0;
   assign wdata[1] = bus.wdata1;

   // Accesses are gated by the registered ready so the cycle that samples init_req still
   // completes, and nothing is accepted while clearing.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         in_rng[p]   = 32'(addr[p]) < DEPTH;
         bank[p]     = BankW'(32'(addr[p]) / BANK_DEPTH);
         off[p]      = OffW'(32'(addr[p]) % BANK_DEPTH);
         rd_req[p]   = ready_q & en[p] & (wea[p] == '0);
         wr_req[p]   = ready_q & en[p] & (wea[p] != '0) & in_rng[p];
         err_d[p]    = ready_q & en[p] & ~in_rng[p];
         rvalid_d[p] = rd_req[p];
         rdata_d[p]  = rdata_q[p];
         if (rd_req[p]) begin
            rdata_d[p] = in_rng[p] ? mem[bank[p]][off[p]] : '0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StClear: begin
            cnt_d = cnt_q + OffW'(1);
            if (cnt_q == OffW'(BANK_DEPTH - 1)) begin
               state_d = StReady;
               cnt_d   = '0;
            end
         end
         StReady: begin
            if (ready_q && bus.init_req) begin
               state_d = StClear;
            end
         end
         default: state_d = StReady;
      endcase
      ready_d = (state_d == StReady);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CLEAR_ON_RESET ? StClear : StReady;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         rvalid_q   <= '0;
         err_q      <= '0;
         rdata_q[0] <= '0;
         rdata_q[1] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         rdata_q[0] <= rdata_d[0];
         rdata_q[1] <= rdata_d[1];
      end
   end

   // Port 1 is applied first so port 0 overrides on lanes both ports enable.
   always_ff @(posedge clk) begin
      if (state_q == StClear) begin
         for (int b = 0; b < NumBanks; b++) begin
            mem[b][cnt_q] <= '0;
         end
      end else begin
         for (int p = 1; p >= 0; p--) begin
            if (wr_req[p]) begin
               for (int i = 0; i < NumBytes; i++) begin
                  if (wea[p][i]) begin
                     mem[bank[p]][off[p]][8*i +: 8] <= wdata[p][8*i +: 8];
                  end
               end
            end
         end
      end
   end

   assign bus.rdata0  = rdata_q[0];
   assign bus.rdata1  = rdata_q[1];
   assign bus.rvalid0 = rvalid_q[0];
   assign bus.rvalid1 = rvalid_q[1];
   assign bus.err0    = err_q[0];
   assign bus.err1    = err_q[1];
   assign bus.ready   = ready_q;
endmodule

// File: tb/tb_sram_banked_dp.sv
// Directed bench for sram_banked_dp: per-cycle vector table plus clear/reset sequences.
module tb_sram_banked_dp;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   sram_banked_dp_if #(.DATA_W(32), .ADDR_W(16)) bus ();

   sram_banked_dp #(
      .DATA_W(32), .DEPTH(16384), .BANK_DEPTH(2048), .ADDR_W(16), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en0;
      logic [3:0]  wea0;
      logic [15:0] addr0;
      logic [31:0] wdata0;
      logic        en1;
      logic [3:0]  wea1;
      logic [15:0] addr1;
      logic [31:0] wdata1;
      logic [31:0] rd0;
      logic        rv0;
      logic        er0;
      logic [31:0] rd1;
      logic        rv1;
      logic        er1;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic e0, input logic [3:0] w0, input logic [15:0] a0,
                        input logic [31:0] d0, input logic e1, input logic [3:0] w1,
                        input logic [15:0] a1, input logic [31:0] d1);
      bus.en0 = e0; bus.wea0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
      bus.en1 = e1; bus.wea1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
   endtask

   task automatic idle();
      drive(1'b0, 4'h0, 16'd0, 32'h0, 1'b0, 4'h0, 16'd0, 32'h0);
      bus.init_req = 1'b0;
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, " rdata0"}, bus.rdata0, 32'h0);
      check({name, " rdata1"}, bus.rdata1, 32'h0);
      check({name, " rvalid/err/ready"},
            32'({bus.rvalid0, bus.rvalid1, bus.err0, bus.err1, bus.ready}), 32'h0);
   endtask

   // Called right after rst_n release / clear start at a negedge; hammers both ports
   // (in-range write, out-of-range read) while counting edges until ready rises.
   task automatic wait_clear(input string name, input bit pulse_init);
      int ready_at = 0;
      bit noisy = 1'b0;
      drive(1'b1, 4'hF, 16'd5, 32'h000000AB, 1'b1, 4'h0, 16'd16384, 32'h0);
      bus.init_req = pulse_init;
      for (int k = 1; k <= 2100 && ready_at == 0; k++) begin
         @(posedge clk);
         #1;
         if (bus.ready) ready_at = k;
         if (bus.rvalid0 | bus.rvalid1 | bus.err0 | bus.err1) noisy = 1'b1;
         if (k == 20) bus.init_req = 1'b0;
      end
      idle();
      check({name, " ready cycle"}, 32'(ready_at), 32'd2048);
      check({name, " quiet in clear"}, 32'(noisy), 32'd0);
   endtask

   task automatic read_pair(input string name, input logic [15:0] a0, input logic [15:0] a1,
                            input logic [31:0] e0, input logic [31:0] e1);
      @(negedge clk);
      drive(1'b1, 4'h0, a0, 32'h0, 1'b1, 4'h0, a1, 32'h0);
      @(posedge clk);
      #1;
      check({name, " rdata0"}, bus.rdata0, e0);
      check({name, " rdata1"}, bus.rdata1, e1);
      check({name, " rvalid"}, 32'({bus.rvalid0, bus.rvalid1}), 32'd3);
      idle();
   endtask

   initial begin
      int quiet;
      vecs[0]  = '{1'b1, 4'h0, 16'd0,     32'h0,        1'b1, 4'h0, 16'd16383, 32'h0,
                   32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
      vecs[1]  = '{1'b1, 4'hF, 16'd2047,  32'hDEADBEEF, 1'b0, 4'h0, 16'd0,     32'h0,
                   32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[2]  = '{1'b0, 4'h0, 16'd0,     32'h0,        1'b1, 4'h1, 16'd2048,  32'h00000011,
                   32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[3]  = '{1'b1, 4'h0, 16'd2047,  32'h0,        1'b1, 4'h0, 16'd2048,  32'h0,
                   32'hDEADBEEF, 1'b1, 1'b0, 32'h00000011, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 4'h3, 16'd100,   32'hAAAAAAAA, 1'b1, 4'h6, 16'd100,   32'hBBBBBBBB,
                   32'hDEADBEEF, 1'b0, 1'b0, 32'h00000011, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 4'h0, 16'd100,   32'h0,        1'b1, 4'h0, 16'd101,   32'h0,
                   32'h00BBAAAA, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
      vecs[6]  = '{1'b1, 4'hF, 16'd100,   32'h5,        1'b0, 4'h0, 16'd0,     32'h0,
                   32'h00BBAAAA, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[7]  = '{1'b1, 4'hF, 16'd100,   32'h9,        1'b1, 4'h0, 16'd100,   32'h0,
                   32'h00BBAAAA, 1'b0, 1'b0, 32'h5,        1'b1, 1'b0};
      vecs[8]  = '{1'b1, 4'h0, 16'd2048,  32'h0,        1'b1, 4'h0, 16'd100,   32'h0,
                   32'h00000011, 1'b1, 1'b0, 32'h9,        1'b1, 1'b0};
      vecs[9]  = '{1'b0, 4'h0, 16'd0,     32'h0,        1'b1, 4'h0, 16'd16384, 32'h0,
                   32'h00000011, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1};
      vecs[10] = '{1'b0, 4'h0, 16'd0,     32'h0,        1'b0, 4'h0, 16'd0,     32'h0,
                   32'h00000011, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[11] = '{1'b1, 4'hF, 16'd0,     32'h0000CAFE, 1'b0, 4'h0, 16'd0,     32'h0,
                   32'h00000011, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[12] = '{1'b0, 4'h0, 16'd0,     32'h0,        1'b1, 4'hF, 16'd16384, 32'h00001234,
                   32'h00000011, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
      vecs[13] = '{1'b1, 4'h0, 16'd0,     32'h0,        1'b0, 4'h0, 16'd0,     32'h0,
                   32'h0000CAFE, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[14] = '{1'b1, 4'h8, 16'd0,     32'hFFFFFFFF, 1'b0, 4'h0, 16'd0,     32'h0,
                   32'h0000CAFE, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[15] = '{1'b1, 4'h0, 16'd0,     32'h0,        1'b1, 4'h0, 16'd2047,  32'h0,
                   32'hFF00CAFE, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0};
      vecs[16] = '{1'b1, 4'h0, 16'hFFFF,  32'h0,        1'b0, 4'h0, 16'd0,     32'h0,
                   32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[17] = '{1'b1, 4'h0, 16'd0,     32'h0,        1'b0, 4'h0, 16'd0,     32'h0,
                   32'hFF00CAFE, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};

      idle();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      bus.en0 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("por reset");
      idle();

      @(negedge clk);
      rst_n = 1'b1;
      wait_clear("por clear", 1'b0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].en0, vecs[i].wea0, vecs[i].addr0, vecs[i].wdata0,
               vecs[i].en1, vecs[i].wea1, vecs[i].addr1, vecs[i].wdata1);
         @(posedge clk);
         #1;
         check($sformatf("v%0d rdata0", i), bus.rdata0, vecs[i].rd0);
         check($sformatf("v%0d rvalid0", i), 32'(bus.rvalid0), 32'(vecs[i].rv0));
         check($sformatf("v%0d err0", i), 32'(bus.err0), 32'(vecs[i].er0));
         check($sformatf("v%0d rdata1", i), bus.rdata1, vecs[i].rd1);
         check($sformatf("v%0d rvalid1", i), 32'(bus.rvalid1), 32'(vecs[i].rv1));
         check($sformatf("v%0d err1", i), 32'(bus.err1), 32'(vecs[i].er1));
         check($sformatf("v%0d ready", i), 32'(bus.ready), 32'd1);
      end
      idle();

      // init_req alongside a read and a write: the access completes, then CLEAR.
      @(negedge clk);
      drive(1'b1, 4'h0, 16'd2047, 32'h0, 1'b1, 4'hF, 16'd3, 32'h00000077);
      bus.init_req = 1'b1;
      @(posedge clk);
      #1;
      check("init access rdata0", bus.rdata0, 32'hDEADBEEF);
      check("init access rvalid0", 32'(bus.rvalid0), 32'd1);
      check("init ready drop", 32'(bus.ready), 32'd0);
      idle();
      drive(1'b1, 4'h0, 16'd0, 32'h0, 1'b1, 4'h0, 16'd16384, 32'h0);
      quiet = 0;
      for (int k = 1; k <= 500; k++) begin
         @(posedge clk);
         #1;
         if (bus.ready | bus.rvalid0 | bus.rvalid1 | bus.err0 | bus.err1) quiet = 1;
      end
      check("init clear quiet", 32'(quiet), 32'd0);
      check("rdata held in clear", bus.rdata1, 32'hDEADBEEF);

      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("abort reset");
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("abort reset hold");
      idle();

      @(negedge clk);
      rst_n = 1'b1;
      wait_clear("restart clear", 1'b1);

      read_pair("after clear a", 16'd3, 16'd2048, 32'h0, 32'h0);
      read_pair("after clear b", 16'd2047, 16'd5, 32'h0, 32'h0);
      read_pair("after clear c", 16'd100, 16'd0, 32'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sram_banked_dp.md
SRAM_BANKED_DP -- requirements
Module: sram_banked_dp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, read/write word width in bits; a multiple of 8.
REQ-002 The block SHALL have parameter DEPTH, default 16384, number of words.
REQ-003 The block SHALL have parameter BANK_DEPTH, default 2048, words per physical bank; DEPTH is a multiple of BANK_DEPTH; NUM_BANKS = DEPTH/BANK_DEPTH.
REQ-004 The block SHALL have parameter ADDR_W, default 16, address width in bits.
REQ-005 The block SHALL have parameter CLEAR_ON_RESET, default 1, which enables a zero-fill of the whole memory after reset release.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en0  input  1  port-0 access request
- wea0  input  DATA_W/8  port-0 byte write enables
- addr0  input  ADDR_W  port-0 word address
- wdata0  input  DATA_W  port-0 write data
- rdata0  output  DATA_W  port-0 registered read data
- rvalid0  output  1  port-0 read data valid
- err0  output  1  port-0 out-of-range pulse
- en1, wea1, addr1, wdata1, rdata1, rvalid1, err1  same as port 0, for port 1
- init_req  input  1  software zero-fill request
- ready  output  1  memory accepting accesses

Function
REQ-007 Each port SHALL decode bank = addr/BANK_DEPTH and offset = addr%BANK_DEPTH independently of the other port.
REQ-008 A read SHALL be a cycle with en=1, wea=0, ready=1; at the next edge rdata SHALL show mem[addr] and rvalid SHALL be 1 for exactly that cycle, giving a read latency of 1.
REQ-009 A write SHALL be a cycle with en=1, wea!=0, ready=1; each byte lane i SHALL be written only where wea[i]=1; rvalid SHALL be 0 on the following cycle.
REQ-010 When rvalid=0, rdata SHALL hold its last value.
REQ-011 If both ports write the same address in the same cycle, each byte lane enabled on both ports SHALL take port-0 data; lanes enabled only on port 1 SHALL take port-1 data.
REQ-012 A read of an address that the other port writes in the same cycle SHALL return the old contents (read-first).
REQ-013 An access with addr >= DEPTH SHALL be out of range:
- any write is suppressed;
- a read returns rdata=0 with rvalid=1;
- err on that port is 1 for one cycle.
REQ-014 The controller SHALL use FSM states CLEAR and READY:
- on reset release, CLEAR if CLEAR_ON_RESET=1, else READY;
- CLEAR -> READY after the last clear write;
- READY -> CLEAR on init_req=1.
REQ-015 In CLEAR, a counter SHALL step 0..BANK_DEPTH-1 and write zero to that offset in all banks in parallel, so a clear takes exactly BANK_DEPTH cycles.
REQ-016 In CLEAR, ready SHALL be 0; en0/en1 SHALL be ignored (no write, no rvalid, no err); init_req SHALL be ignored.
REQ-017 ready SHALL be 1 from the cycle after the final clear write, or from the first edge after reset release when CLEAR_ON_RESET=0.
REQ-018 An init_req sampled in the same cycle as a READY access SHALL let that access complete, and CLEAR SHALL begin at the next cycle.

Reset
REQ-019 While rst_n=0, the block SHALL drive rdata0=rdata1=0, rvalid0=rvalid1=0, err0=err1=0, ready=0, and SHALL reset the clear counter to 0.
REQ-020 Assertion of rst_n during CLEAR SHALL abort the clear; on release the FSM SHALL restart from counter 0 per REQ-014.
REQ-021 Reset SHALL NOT be required to alter array contents; only a completed CLEAR guarantees zeros.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- Reset release with defaults -> ready=0 for 2048 cycles, then 1; a read of any address in 0..16383 returns 0x00000000 with rvalid=1 one cycle later.
- Port 0 writes 0xDEADBEEF at address 2047, wea=4'b1111; port 1 then writes 0x11 at address 2048, wea=4'b0001; port 0 reads 2047 and port 1 reads 2048 in the same cycle -> next cycle rdata0=0xDEADBEEF and rdata1=0x00000011, both rvalid=1.
- Both ports write address 100 in the same cycle (port 0: 0xAAAAAAAA, wea=4'b0011; port 1: 0xBBBBBBBB, wea=4'b0110) -> read 100 returns 0x00BBAAAA.
- Address 100 holds 0x5; port 1 reads 100 while port 0 writes 0x9 to 100 -> rdata1=0x5; a subsequent read returns 0x9.
- Port 1 reads address 16384 -> rdata1=0, rvalid1=1, err1=1 for one cycle; a write to 16384 leaves address 0 unchanged.
- init_req in READY, then rst_n pulsed low at clear cycle 500 -> all outputs 0 during reset, clear restarts at 0, ready=1 exactly 2048 cycles after release, accesses during CLEAR produce no rvalid.
